// File: rtl/bimodal_btb_predictor_if.sv
// ----------------------------------------------------------------------------
// bimodal_btb_predictor_if
// Groups the pipeline-facing signals of the next-PC predictor.
//   master : pipeline side; drives the IF fetch PC, the EX resolution info
//            and the stall, and receives the prediction/flush/perf counters.
//   slave  : predictor side.
// Signals:
//   i_stall, i_pc_if                          IF-stage inputs
//   i_pc_ex, i_is_br_ex, i_is_jump_ex,
//   i_taken_ex, i_target_ex                   EX-stage resolution inputs
//   o_next_pc, o_pred_taken_if, o_flush       next-PC selection
//   o_br_cnt, o_mispred_cnt                   saturating perf counters
// ----------------------------------------------------------------------------
interface bimodal_btb_predictor_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    logic             i_stall;
    logic [XLEN-1:0]  i_pc_if;
    logic [XLEN-1:0]  i_pc_ex;
    logic             i_is_br_ex;
    logic             i_is_jump_ex;
    logic             i_taken_ex;
    logic [XLEN-1:0]  i_target_ex;
    logic [XLEN-1:0]  o_next_pc;
    logic             o_pred_taken_if;
    logic             o_flush;
    logic [CNT_W-1:0] o_br_cnt;
    logic [CNT_W-1:0] o_mispred_cnt;

    modport master (
        output i_stall, i_pc_if, i_pc_ex, i_is_br_ex, i_is_jump_ex, i_taken_ex, i_target_ex,
        input  o_next_pc, o_pred_taken_if, o_flush, o_br_cnt, o_mispred_cnt
    );

    modport slave (
        input  i_stall, i_pc_if, i_pc_ex, i_is_br_ex, i_is_jump_ex, i_taken_ex, i_target_ex,
        output o_next_pc, o_pred_taken_if, o_flush, o_br_cnt, o_mispred_cnt
    );
endinterface

// File: rtl/bimodal_btb_predictor.sv
// ----------------------------------------------------------------------------
// bimodal_btb_predictor
// IF-stage next-PC predictor: direct-mapped BTB with 2-bit saturating
// direction counters. The IF prediction is carried through ID (pid) and EX
// (pex), compared with the EX outcome, and a mismatch raises o_flush with the
// corrected PC on o_next_pc in the same cycle.
// Ports:
//   i_clk    clock, all state on the rising edge
//   i_rst_n  synchronous active-low reset
//   bus      slave modport of bimodal_btb_predictor_if (IF/EX inputs,
//            next PC, prediction, flush, perf counters)
// MODE 0 degrades to static not-taken: the table is never read or written.
// ----------------------------------------------------------------------------
module bimodal_btb_predictor #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned MODE    = 1,
    parameter int unsigned CNT_W   = 32
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    bimodal_btb_predictor_if.slave bus
);
    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX - 2;
    localparam bit          BIMODAL = (MODE == 1);

    // BTB storage
    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] is_jump_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    // Prediction tracking: ID and EX copies of {taken, target}
    logic            pid_taken_q, pex_taken_q;
    logic [XLEN-1:0] pid_target_q, pex_target_q;

    logic [CNT_W-1:0] br_cnt_q, mispred_cnt_q;

    // IF lookup
    logic [IDX-1:0]   idx_if;
    logic [TAG_W-1:0] tag_if;
    logic             hit_if;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;

    // EX resolution
    logic [IDX-1:0]   idx_ex;
    logic [TAG_W-1:0] tag_ex;
    logic             hit_ex;
    logic             res;
    logic             act;
    logic             flush;
    logic [XLEN-1:0]  correct_pc;
    logic             tbl_we;

    always_comb begin
        idx_if      = bus.i_pc_if[IDX+1:2];
        tag_if      = bus.i_pc_if[XLEN-1:IDX+2];
        hit_if      = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
        pred_taken  = BIMODAL && hit_if && (is_jump_q[idx_if] || ctr_q[idx_if][1]);
        pred_target = target_q[idx_if];

        idx_ex = bus.i_pc_ex[IDX+1:2];
        tag_ex = bus.i_pc_ex[XLEN-1:IDX+2];
        hit_ex = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);

        res   = bus.i_is_br_ex | bus.i_is_jump_ex;
        act   = bus.i_is_jump_ex | bus.i_taken_ex;
        flush = res && ((act != pex_taken_q) ||
                        (act && (bus.i_target_ex != pex_target_q)));
        correct_pc = act ? bus.i_target_ex : bus.i_pc_ex + XLEN'(4);
        tbl_we     = BIMODAL && res;
    end

    always_comb begin
        if (flush) begin
            bus.o_next_pc = correct_pc;
        end else if (pred_taken) begin
            bus.o_next_pc = pred_target;
        end else begin
            bus.o_next_pc = bus.i_pc_if + XLEN'(4);
        end
        bus.o_pred_taken_if = pred_taken;
        bus.o_flush         = flush;
        bus.o_br_cnt        = br_cnt_q;
        bus.o_mispred_cnt   = mispred_cnt_q;
    end

    // Valid bits and direction counters; the only table state needing reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= 2'd1;
            end
        end else if (tbl_we) begin
            if (act) begin
                if (hit_ex) begin
                    ctr_q[idx_ex] <= (ctr_q[idx_ex] == 2'd3) ? 2'd3 : ctr_q[idx_ex] + 2'd1;
                end else begin
                    valid_q[idx_ex] <= 1'b1;
                    ctr_q[idx_ex]   <= 2'd2;
                end
            end else if (hit_ex) begin
                ctr_q[idx_ex] <= (ctr_q[idx_ex] == 2'd0) ? 2'd0 : ctr_q[idx_ex] - 2'd1;
            end
        end
    end

    // Tag/target/kind payload: written on any taken resolution (refresh on
    // hit, allocate on miss); meaningless while the valid bit is clear.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && tbl_we && act) begin
            tag_q[idx_ex]     <= tag_ex;
            target_q[idx_ex]  <= bus.i_target_ex;
            is_jump_q[idx_ex] <= bus.i_is_jump_ex;
        end
    end

    // Prediction tracking; flush wins over stall.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || flush) begin
            pid_taken_q  <= 1'b0;
            pid_target_q <= '0;
            pex_taken_q  <= 1'b0;
            pex_target_q <= '0;
        end else if (bus.i_stall) begin
            pex_taken_q  <= 1'b0;
            pex_target_q <= '0;
        end else begin
            pid_taken_q  <= pred_taken;
            pid_target_q <= pred_taken ? pred_target : '0;
            pex_taken_q  <= pid_taken_q;
            pex_target_q <= pid_target_q;
        end
    end

    // Saturating performance counters
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (res && (br_cnt_q != '1)) begin
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            end
            if (flush && (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: doc/bimodal_btb_predictor.md
# bimodal_btb_predictor

Parametrised next-PC predictor for the 5-stage RV32I pipeline: a direct-mapped branch target buffer with 2-bit saturating direction counters. It supersedes fixed not-taken prediction. The block sits in the IF stage and predicts the next PC. It carries each prediction alongside the instruction through ID into EX, resolves it against the EX outcome, and raises the flush/redirect. It also keeps saturating branch and mispredict counters for performance measurement.

## Interface
- `XLEN`, 32: PC/target width.
- `ENTRIES`, 16: BTB depth; power of two, 2..256; `IDX = log2(ENTRIES)`.
- `MODE`, 1: 0 = static not-taken (table never read or written); 1 = bimodal BTB.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_stall`  in  1  load-use stall from the hazard unit; holds PC and IF/ID.
- `i_pc_if`  in  XLEN  current fetch PC.
- `i_pc_ex`  in  XLEN  PC of the instruction in EX.
- `i_is_br_ex`  in  1  EX instruction is a conditional branch.
- `i_is_jump_ex`  in  1  EX instruction is a JAL/JALR.
- `i_taken_ex`  in  1  branch comparator result in EX.
- `i_target_ex`  in  XLEN  computed target (ALU result) in EX.
- `o_next_pc`  out  XLEN  next fetch PC.
- `o_pred_taken_if`  out  1  IF prediction is taken.
- `o_flush`  out  1  mispredict; squash IF/ID and ID/EX.
- `o_br_cnt`  out  CNT_W  count of resolved branches and jumps.
- `o_mispred_cnt`  out  CNT_W  count of mispredicts.

## Operation
- Index is `pc[IDX+1:2]`. Tag is `pc[XLEN-1:IDX+2]`.
- Each entry holds: `valid`, `tag`, `target`, `is_jump`, `ctr[1:0]`.
- IF lookup is combinational.
  - `hit` = `valid` and tag match.
  - `pred_taken` = `MODE==1` && `hit` && (`is_jump` || `ctr[1]`).
  - `pred_target` = `target` of the hit entry.
- `o_next_pc` priority:
  1. `o_flush` selects `correct_pc`.
  2. `pred_taken` selects `pred_target`.
  3. Otherwise `i_pc_if+4`.
- Tracking registers `pid` (ID) and `pex` (EX) each hold {`taken`, `target`}. On each edge:
  - Reset or `o_flush`: both cleared to 0.
  - Else `i_stall`: `pid` holds; `pex` cleared (bubble).
  - Else: `pid` takes the IF prediction; `pex` takes `pid`.
- Resolution (`res` = `i_is_br_ex` | `i_is_jump_ex`):
  - `act` = `i_is_jump_ex` | `i_taken_ex`.
  - `o_flush` = `res` && (`act` != `pex.taken` || (`act` && `i_target_ex` != `pex.target`)).
  - `correct_pc` = `act` ? `i_target_ex` : `i_pc_ex+4`.
  - Bubbles arrive with `i_is_br_ex`/`i_is_jump_ex` low.
- Table update on `res`, MODE 1 only, at the index of `i_pc_ex`:
  - Taken, hit: refresh `target` and `is_jump`; `ctr` increments, saturating at 3.
  - Taken, miss: allocate with `valid`=1, new tag and target, `ctr`=2.
  - Not taken, hit: `ctr` decrements, saturating at 0.
  - Not taken, miss: no write.
- Counters, both saturating at all-ones:
  - `o_br_cnt` +1 on every `res`.
  - `o_mispred_cnt` +1 on every `o_flush`.
- MODE 0: `pred_taken` is always 0, so every taken branch and every jump flushes.

## Timing
- Reset values:
  - All entries `valid`=0, `ctr`=1.
  - `pid` and `pex` = 0.
  - Both counters = 0.
  - Outputs then: `o_flush`=0, `o_pred_taken_if`=0, `o_next_pc`=`i_pc_if+4`.
- Prediction latency is 0 cycles (same-cycle combinational lookup).
- Mispredict penalty is 2 cycles; `o_flush` is combinational in the resolving cycle.
- A table write becomes visible to IF lookup the cycle after resolution. A same-cycle lookup of the same index reads the old contents.
- `o_flush` overrides `i_stall`: the PC must load `o_next_pc` when `o_flush`=1. The datapath gates the PC/IF-ID stall with `~o_flush`.
- Reset asserted mid-operation clears all state at the next edge, including in-flight tracking; no update from the cycle in which reset is sampled.

## Test plan
- **Cold branch, not taken.** After reset, branch at 0x40 resolves not-taken -> `o_flush`=0; no allocation (a lookup at 0x40 still misses); `o_br_cnt`=1.
- **Cold branch, taken.** Branch at 0x40, taken to 0x80 -> `o_flush`=1 and `o_next_pc`=0x80. Next fetch of 0x40 predicts taken with `o_next_pc`=0x80 (`ctr`=2). Second taken resolution gives no flush; `o_mispred_cnt` stays 1.
- **Counter hysteresis.** Entry at 0x40 with `ctr`=3, then not-taken twice -> both resolutions flush with `o_next_pc`=0x44; `ctr` goes 3->2->1; the following fetch predicts not-taken.
- **Aliasing.** ENTRIES=16: branch at 0x40 allocated, then fetch 0x80 (same index, different tag) -> miss, not-taken. Jump at 0x80 taken to 0x200 overwrites the entry; 0x40 then misses.
- **Stall and target mismatch.** Predicted-taken JALR at 0x10 resolving to 0x300 with 0x100 stored -> flush, `o_next_pc`=0x300. `i_stall`=1 for one cycle with a prediction in ID -> `pex` bubbles, and `pid` reaches EX one cycle later unchanged.
- **Static mode and saturation.** MODE=0, jump at 0x20 -> every resolution flushes and `o_pred_taken_if` never asserts. CNT_W=4: 16 resolutions -> `o_br_cnt` holds 0xF.
